// File: rtl/decoder_2x4_df.sv
// Clocked 2-to-4 one-hot decoder with registered outputs and a change strobe.
// Optional per-line hit counters are compiled in with DECODER_2X4_DF_HIT_CNT_EN.
module decoder_2x4_df #(
   parameter bit          ACTIVE_LOW = 1'b0,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             a,
   input  logic             b,
   output logic             q0,
   output logic             q1,
   output logic             q2,
   output logic             q3,
   output logic             changed
`ifdef DECODER_2X4_DF_HIT_CNT_EN
   ,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] hit0,
   output logic [CNT_W-1:0] hit1,
   output logic [CNT_W-1:0] hit2,
   output logic [CNT_W-1:0] hit3
`endif
);

   if (CNT_W == 0) begin : g_cnt_w_chk
      $error("CNT_W must be at least 1");
   end

   logic [1:0] idx;
   logic [3:0] line_d, line_q;
   logic       changed_d, changed_q;

   assign idx = {a, b};

   // line_q is kept active-high internally; polarity is applied only at the pins.
   always_comb begin
      line_d    = en ? (4'b0001 << idx) : 4'b0000;
      changed_d = (line_d != line_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_q    <= 4'b0000;
         changed_q <= 1'b0;
      end else begin
         line_q    <= line_d;
         changed_q <= changed_d;
      end
   end

   always_comb begin
      {q3, q2, q1, q0} = line_q ^ {4{ACTIVE_LOW}};
      changed          = changed_q;
   end

`ifdef DECODER_2X4_DF_HIT_CNT_EN
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] hit_d [4];
   logic [CNT_W-1:0] hit_q [4];

   // Counters saturate; clr_cnt wins over a same-cycle increment.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         hit_d[i] = hit_q[i];
         if (clr_cnt) begin
            hit_d[i] = '0;
         end else if (line_d[i] && hit_q[i] != CntMax) begin
            hit_d[i] = hit_q[i] + CntOne;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) hit_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) hit_q[i] <= hit_d[i];
      end
   end

   assign hit0 = hit_q[0];
   assign hit1 = hit_q[1];
   assign hit2 = hit_q[2];
   assign hit3 = hit_q[3];
`endif

endmodule

// File: tb/tb_decoder_2x4_df.sv
// Randomized bench for decoder_2x4_df: two instances (active-high and active-low)
// share stimulus and are checked against an index-level reference model.
module tb_decoder_2x4_df;

   logic clk = 1'b0;
   logic clk_run = 1'b0;
   logic rst, en, a, b, clr_cnt;
   logic q0_h, q1_h, q2_h, q3_h, chg_h;
   logic q0_l, q1_l, q2_l, q3_l, chg_l;
`ifdef DECODER_2X4_DF_HIT_CNT_EN
   logic [1:0] hit0, hit1, hit2, hit3;
   logic [1:0] hit0_l, hit1_l, hit2_l, hit3_l;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: active line index (-1 = all idle) and hit counts.
   int prev_idx = -1;
   int cnt [4];

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   decoder_2x4_df #(.ACTIVE_LOW(1'b0), .CNT_W(2)) u_dut_h (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
      .q0(q0_h), .q1(q1_h), .q2(q2_h), .q3(q3_h), .changed(chg_h)
`ifdef DECODER_2X4_DF_HIT_CNT_EN
      , .clr_cnt(clr_cnt), .hit0(hit0), .hit1(hit1), .hit2(hit2), .hit3(hit3)
`endif
   );

   decoder_2x4_df #(.ACTIVE_LOW(1'b1), .CNT_W(2)) u_dut_l (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
      .q0(q0_l), .q1(q1_l), .q2(q2_l), .q3(q3_l), .changed(chg_l)
`ifdef DECODER_2X4_DF_HIT_CNT_EN
      , .clr_cnt(clr_cnt), .hit0(hit0_l), .hit1(hit1_l), .hit2(hit2_l), .hit3(hit3_l)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_vec(input int idx, input bit active_low);
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = (i == idx) ? ~active_low : active_low;
      return v;
   endfunction

   task automatic check_all(input string tag, input bit exp_chg);
      check({tag, "_q_hi"}, {28'd0, q3_h, q2_h, q1_h, q0_h}, {28'd0, exp_vec(prev_idx, 1'b0)});
      check({tag, "_q_lo"}, {28'd0, q3_l, q2_l, q1_l, q0_l}, {28'd0, exp_vec(prev_idx, 1'b1)});
      check({tag, "_chg_hi"}, {31'd0, chg_h}, {31'd0, exp_chg});
      check({tag, "_chg_lo"}, {31'd0, chg_l}, {31'd0, exp_chg});
`ifdef DECODER_2X4_DF_HIT_CNT_EN
      check({tag, "_hit"}, {24'd0, hit3, hit2, hit1, hit0},
            {24'd0, 2'(cnt[3]), 2'(cnt[2]), 2'(cnt[1]), 2'(cnt[0])});
      check({tag, "_hit_lo"}, {24'd0, hit3_l, hit2_l, hit1_l, hit0_l},
            {24'd0, 2'(cnt[3]), 2'(cnt[2]), 2'(cnt[1]), 2'(cnt[0])});
`endif
   endtask

   // Apply inputs, take one edge, advance the model, compare 1 time unit later.
   task automatic step(input string tag, input bit e, input int sel, input bit clr);
      int  idx;
      bit  chg;
      en      = e;
      a       = sel[1];
      b       = sel[0];
      clr_cnt = clr;
      @(posedge clk);
      #1;
      idx = e ? sel : -1;
      chg = (idx != prev_idx);
      prev_idx = idx;
      if (clr) begin
         for (int i = 0; i < 4; i++) cnt[i] = 0;
      end else if (e && cnt[sel] < 3) begin
         cnt[sel] = cnt[sel] + 1;
      end
      check_all(tag, chg);
   endtask

   task automatic model_reset();
      prev_idx = -1;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
   endtask

   initial begin
      en = 1'b0; a = 1'b0; b = 1'b0; clr_cnt = 1'b0;
      model_reset();

      // Reset with clock stopped.
      rst = 1'b1;
      #3;
      check_all("rst_noclk", 1'b0);
      rst = 1'b0;
      #2;
      clk_run = 1'b1;

      step("first", 1'b1, 0, 1'b0);

      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 10; c++) step("sweep", 1'b1, s, 1'b0);
      end

      step("en_on", 1'b1, 3, 1'b0);
      step("en_off", 1'b0, 3, 1'b0);
      step("en_on2", 1'b1, 3, 1'b0);

      // Async reset pulsed between edges while q1 active.
      step("pre_rst", 1'b1, 1, 1'b0);
      step("pre_rst2", 1'b1, 1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst", 1'b0);
      #1;
      rst = 1'b0;
      step("post_rst", 1'b1, 1, 1'b0);

      // Counter saturation and clear priority (counters only in that build).
      step("clr", 1'b1, 0, 1'b1);
      for (int c = 0; c < 5; c++) step("sat", 1'b1, 0, 1'b0);
      step("clr_prio", 1'b1, 0, 1'b1);

      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 39) == 0) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            model_reset();
            check_all("rnd_rst", 1'b0);
            #1;
            rst = 1'b0;
         end
         step("rnd", $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
              $urandom_range(0, 19) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
